// File: rtl/multi_phase_clock_gen.sv
// Multi-phase clock-enable generator: NUM_CH programmable phase windows
// over a CYCLE_LEN-clk machine cycle, with run/halt/single-step control.
//
// Ports:
//   clk, reset                     clock, sync active-high reset
//   start, halt_req, step          run control
//   cfg_we/cfg_ch/cfg_start/cfg_width  shadow config write port
//   ch_level, ch_rise              per-channel level and rising strobe
//   phase_cnt, cycle_done          phase within cycle, last-phase flag
//   running, state                 RUN|DRAIN flag, FSM state
module multi_phase_clock_gen #(
  parameter int NUM_CH    = 2,
  parameter int CYCLE_LEN = 4,
  parameter int CW        = $clog2(CYCLE_LEN),
  parameter int IW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              step,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_ch,
  input  logic [CW-1:0]     cfg_start,
  input  logic [CW:0]       cfg_width,
  output logic [NUM_CH-1:0] ch_level,
  output logic [NUM_CH-1:0] ch_rise,
  output logic [CW-1:0]     phase_cnt,
  output logic              cycle_done,
  output logic              running,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(CYCLE_LEN - 1);
  localparam logic [CW:0]   LEN  = (CW+1)'(CYCLE_LEN);

  state_t cur, nxt;

  logic [CW-1:0] cnt_nxt;
  logic          run_nxt;
  logic          copy;
  logic [CW-1:0] start_mod;
  logic [CW:0]   diff;

  logic [NUM_CH-1:0] level_nxt;

  logic [CW-1:0] sh_start    [NUM_CH];
  logic [CW-1:0] sh_start_n  [NUM_CH];
  logic [CW-1:0] act_start   [NUM_CH];
  logic [CW-1:0] act_start_n [NUM_CH];
  logic [CW:0]   sh_width    [NUM_CH];
  logic [CW:0]   sh_width_n  [NUM_CH];
  logic [CW:0]   act_width   [NUM_CH];
  logic [CW:0]   act_width_n [NUM_CH];

  assign state      = cur;
  assign running    = (cur == RUN) || (cur == DRAIN);
  assign cycle_done = running && (phase_cnt == LAST);

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:   if (start) nxt = RUN;
      RUN:    if (halt_req)
                nxt = (phase_cnt == LAST) ? HALTED : DRAIN;
      DRAIN:  if (phase_cnt == LAST) nxt = HALTED;
      HALTED: if (start) nxt = RUN;
              else if (step) nxt = DRAIN;
      default: nxt = IDLE;
    endcase
  end

  // Entering RUN/DRAIN from a stopped state starts at phase 0.
  always_comb begin
    run_nxt = (nxt == RUN) || (nxt == DRAIN);
    cnt_nxt = '0;
    if (run_nxt && running)
      cnt_nxt = (phase_cnt == LAST) ? '0 : phase_cnt + CW'(1);
  end

  // The write lands in the shadow first; the same clk's copy sees it.
  always_comb begin
    start_mod = CW'(int'(cfg_start) % CYCLE_LEN);
    for (int i = 0; i < NUM_CH; i++) begin
      sh_start_n[i] = sh_start[i];
      sh_width_n[i] = sh_width[i];
    end
    if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
      sh_start_n[cfg_ch] = start_mod;
      sh_width_n[cfg_ch] = cfg_width;
    end
    copy = !running || (cnt_nxt == '0);
    for (int i = 0; i < NUM_CH; i++) begin
      act_start_n[i] = copy ? sh_start_n[i] : act_start[i];
      act_width_n[i] = copy ? sh_width_n[i] : act_width[i];
    end
  end

  // Distance from window start, modulo the cycle length; a width
  // of CYCLE_LEN or more covers every phase.
  always_comb begin
    level_nxt = '0;
    diff      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      diff = {1'b0, cnt_nxt} - {1'b0, act_start_n[i]};
      if (cnt_nxt < act_start_n[i])
        diff = diff + LEN;
      level_nxt[i] = run_nxt && (diff < act_width_n[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= IDLE;
      phase_cnt <= '0;
      ch_level  <= '0;
      ch_rise   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_start[i]  <= CW'(i * CYCLE_LEN / NUM_CH);
        act_start[i] <= CW'(i * CYCLE_LEN / NUM_CH);
        sh_width[i]  <= (CW+1)'(CYCLE_LEN / NUM_CH);
        act_width[i] <= (CW+1)'(CYCLE_LEN / NUM_CH);
      end
    end else begin
      cur       <= nxt;
      phase_cnt <= cnt_nxt;
      ch_level  <= level_nxt;
      ch_rise   <= level_nxt & ~ch_level;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_start[i]  <= sh_start_n[i];
        act_start[i] <= act_start_n[i];
        sh_width[i]  <= sh_width_n[i];
        act_width[i] <= act_width_n[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_phase_clock_gen.sv
// Directed bench for multi_phase_clock_gen: a 2-ch/len-4 instance
// for control and config, a 3-ch/len-6 instance for default windows.
module tb_multi_phase_clock_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, halt_req, step, cfg_we;
  logic [0:0] cfg_ch;
  logic [1:0] cfg_start;
  logic [2:0] cfg_width;
  logic [1:0] ch_level, ch_rise, phase_cnt, state;
  logic       cycle_done, running;

  logic       reset2, start2, halt2, step2, cfg_we2;
  logic [1:0] cfg_ch2;
  logic [2:0] cfg_start2;
  logic [3:0] cfg_width2;
  logic [2:0] ch_level2, ch_rise2, phase_cnt2;
  logic [1:0] state2;
  logic       cycle_done2, running2;

  int n_chk = 0;
  int n_fail = 0;

  multi_phase_clock_gen #(.NUM_CH(2), .CYCLE_LEN(4)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .step(step), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_start(cfg_start), .cfg_width(cfg_width),
    .ch_level(ch_level), .ch_rise(ch_rise), .phase_cnt(phase_cnt),
    .cycle_done(cycle_done), .running(running), .state(state)
  );

  multi_phase_clock_gen #(.NUM_CH(3), .CYCLE_LEN(6)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .halt_req(halt2),
    .step(step2), .cfg_we(cfg_we2), .cfg_ch(cfg_ch2),
    .cfg_start(cfg_start2), .cfg_width(cfg_width2),
    .ch_level(ch_level2), .ch_rise(ch_rise2), .phase_cnt(phase_cnt2),
    .cycle_done(cycle_done2), .running(running2), .state(state2)
  );

  // {state, phase, level, rise, cycle_done, running}
  function automatic logic [9:0] obs();
    return {state, phase_cnt, ch_level, ch_rise, cycle_done, running};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    tick();
    tick();
    got = obs();
    n_chk++;
    if (got !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_held got=%b exp=%b", got, 10'b0);
    end
    reset = 1'b0;
    tick();
    got = obs();
    n_chk++;
    if (got !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_idle got=%b exp=%b", got, 10'b0);
    end
    step = 1'b1;
    halt_req = 1'b1;
    tick();
    step = 1'b0;
    halt_req = 1'b0;
    got = obs();
    n_chk++;
    if (got !== 10'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_step got=%b exp=%b", got, 10'b0);
    end
  endtask

  task automatic test_run();
    logic [1:0] ph, lvl, rs;
    logic [9:0] exp, got;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ph  = 2'(k % 4);
      lvl = (ph < 2) ? 2'b01 : 2'b10;
      rs  = (ph == 0) ? 2'b01 : (ph == 2) ? 2'b10 : 2'b00;
      exp = {2'b01, ph, lvl, rs, (ph == 2'd3), 1'b1};
      got = obs();
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL run k=%0d got=%b exp=%b", k, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [9:0] exp [4];
    logic [9:0] got;
    exp[0] = {2'b10, 2'd2, 2'b10, 2'b10, 1'b0, 1'b1};
    exp[1] = {2'b10, 2'd3, 2'b10, 2'b00, 1'b1, 1'b1};
    exp[2] = 10'b11_00_00_00_0_0;
    exp[3] = 10'b11_00_00_00_0_0;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = obs();
      n_chk++;
      if (got !== exp[i]) begin
        n_fail++;
        $display("FAIL halt i=%0d got=%b exp=%b", i, got, exp[i]);
      end
      if (i == 0) begin
        start = 1'b1;
        step = 1'b1;
        halt_req = 1'b1;
      end else if (i == 2) begin
        halt_req = 1'b1;
      end
      tick();
      start = 1'b0;
      step = 1'b0;
      halt_req = 1'b0;
    end
  endtask

  task automatic test_step();
    logic [9:0] e1 [6];
    logic [9:0] e2 [5];
    logic [9:0] got;
    e1[0] = {2'b10, 2'd0, 2'b01, 2'b01, 1'b0, 1'b1};
    e1[1] = {2'b10, 2'd1, 2'b01, 2'b00, 1'b0, 1'b1};
    e1[2] = {2'b10, 2'd2, 2'b10, 2'b10, 1'b0, 1'b1};
    e1[3] = {2'b10, 2'd3, 2'b10, 2'b00, 1'b1, 1'b1};
    e1[4] = 10'b11_00_00_00_0_0;
    e1[5] = 10'b11_00_00_00_0_0;
    e2[0] = {2'b01, 2'd0, 2'b01, 2'b01, 1'b0, 1'b1};
    e2[1] = {2'b01, 2'd1, 2'b01, 2'b00, 1'b0, 1'b1};
    e2[2] = {2'b01, 2'd2, 2'b10, 2'b10, 1'b0, 1'b1};
    e2[3] = {2'b01, 2'd3, 2'b10, 2'b00, 1'b1, 1'b1};
    e2[4] = {2'b01, 2'd0, 2'b01, 2'b01, 1'b0, 1'b1};
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      got = obs();
      n_chk++;
      if (got !== e1[i]) begin
        n_fail++;
        $display("FAIL step i=%0d got=%b exp=%b", i, got, e1[i]);
      end
      tick();
    end
    start = 1'b1;
    step = 1'b1;
    tick();
    start = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got = obs();
      n_chk++;
      if (got !== e2[i]) begin
        n_fail++;
        $display("FAIL start_step i=%0d got=%b exp=%b", i, got, e2[i]);
      end
      tick();
    end
  endtask

  task automatic test_wrap_window();
    logic [9:0] ew [7];
    logic [1:0] e0 [6];
    logic [1:0] e7 [7];
    logic [9:0] got;
    ew[0] = {2'b01, 2'd2, 2'b10, 2'b10, 1'b0, 1'b1};
    ew[1] = {2'b01, 2'd3, 2'b10, 2'b00, 1'b1, 1'b1};
    ew[2] = {2'b01, 2'd0, 2'b01, 2'b01, 1'b0, 1'b1};
    ew[3] = {2'b01, 2'd1, 2'b00, 2'b00, 1'b0, 1'b1};
    ew[4] = {2'b01, 2'd2, 2'b10, 2'b10, 1'b0, 1'b1};
    ew[5] = {2'b01, 2'd3, 2'b11, 2'b01, 1'b1, 1'b1};
    ew[6] = {2'b01, 2'd0, 2'b01, 2'b00, 1'b0, 1'b1};
    e0 = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10};
    e7 = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11};
    cfg_we = 1'b1;
    cfg_ch = 1'b0;
    cfg_start = 2'd3;
    cfg_width = 3'd2;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 7; i++) begin
      got = obs();
      n_chk++;
      if (got !== ew[i]) begin
        n_fail++;
        $display("FAIL wrap i=%0d got=%b exp=%b", i, got, ew[i]);
      end
      tick();
    end
    cfg_we = 1'b1;
    cfg_width = 3'd0;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (ch_level !== e0[i]) begin
        n_fail++;
        $display("FAIL width0 i=%0d got=%b exp=%b", i, ch_level, e0[i]);
      end
      tick();
    end
    cfg_we = 1'b1;
    cfg_width = 3'd7;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (ch_level !== e7[i]) begin
        n_fail++;
        $display("FAIL width7 i=%0d got=%b exp=%b", i, ch_level, e7[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] er [5];
    logic [9:0] got;
    er[0] = {2'b01, 2'd0, 2'b01, 2'b01, 1'b0, 1'b1};
    er[1] = {2'b01, 2'd1, 2'b01, 2'b00, 1'b0, 1'b1};
    er[2] = {2'b01, 2'd2, 2'b10, 2'b10, 1'b0, 1'b1};
    er[3] = {2'b01, 2'd3, 2'b10, 2'b00, 1'b1, 1'b1};
    er[4] = 10'b11_00_00_00_0_0;
    tick();
    tick();
    n_chk++;
    if ({state, phase_cnt} !== 4'b01_10) begin
      n_fail++;
      $display("FAIL pre_reset got=%b exp=%b", {state, phase_cnt}, 4'b0110);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = obs();
    n_chk++;
    if (got !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_reset got=%b exp=%b", got, 10'b0);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got = obs();
      n_chk++;
      if (got !== er[i]) begin
        n_fail++;
        $display("FAIL restart i=%0d got=%b exp=%b", i, got, er[i]);
      end
      if (i == 3) halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
    end
  endtask

  task automatic test_sweep();
    logic [2:0]  ph, lvl, rs;
    logic [11:0] exp, got;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    tick();
    got = {state2, phase_cnt2, ch_level2, ch_rise2, cycle_done2};
    n_chk++;
    if (got !== 12'b0) begin
      n_fail++;
      $display("FAIL sweep_reset got=%b exp=%b", got, 12'b0);
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ph  = 3'(k % 6);
      lvl = 3'b001 << (ph / 2);
      rs  = (ph[0] == 1'b0) ? lvl : 3'b000;
      exp = {2'b01, ph, lvl, rs, (ph == 3'd5)};
      got = {state2, phase_cnt2, ch_level2, ch_rise2, cycle_done2};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sweep k=%0d got=%b exp=%b", k, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    halt_req = 1'b0;
    step = 1'b0;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_start = '0;
    cfg_width = '0;
    reset2 = 1'b1;
    start2 = 1'b0;
    halt2 = 1'b0;
    step2 = 1'b0;
    cfg_we2 = 1'b0;
    cfg_ch2 = '0;
    cfg_start2 = '0;
    cfg_width2 = '0;
    test_reset();
    test_run();
    test_halt();
    test_step();
    test_wrap_window();
    test_reset_mid_run();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
